spu_slotsequencer: RTL
======================

Name: spu_slotSequencer

Overview:
- Master timing generator for the SPU sample frame.
- Divides each 768-cycle frame (44.1 kHz at 33.8688 MHz) into 32 slots of 24 cycles: slots 0..23 are voice slots, slots 24..31 are reverb slots.
- Drives the per-voice state decoder directly upstream with the in-slot cycle counter, current voice index, voice/reverb phase flag and voice 1/3 flags.
- Also maintains the capture-buffer write index and a frame-start strobe.

Parameters:
- SLOT_CYCLES, 24, clock cycles per slot; range 20..32, because the downstream decoder uses cycles 0..18.
- NUM_SLOTS, 32, slots per frame.
- NUM_VOICES, 24, leading slots treated as voice slots; must be less than NUM_SLOTS.
- CAPTURE_DEPTH_LOG2, 9, capture index width (512 halfwords per capture buffer).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_spuEnable  in  1  SPUCNT enable bit; 0 holds the sequencer idle
- o_voiceCounter  out  5  cycle index within the current slot
- o_currVoice  out  5  current slot index, 0..NUM_SLOTS-1
- o_reverbInactive  out  1  1 = running and in a voice slot
- o_reverbSlot  out  3  o_currVoice - NUM_VOICES when in a reverb slot, else 0
- o_isVoice1  out  1  running and o_currVoice == 1
- o_isVoice3  out  1  running and o_currVoice == 3
- o_frameStart  out  1  one-cycle pulse at slot 0, cycle 0
- o_frameEnd  out  1  one-cycle pulse at the last cycle of the last slot
- o_captureIndex  out  CAPTURE_DEPTH_LOG2  capture buffer write index

Behaviour:
- State registers:
  - run flag
  - cycCnt, 5 bits
  - slotCnt, 5 bits
  - capIdx, CAPTURE_DEPTH_LOG2 bits
- Output decoding:
  - All outputs are pure decodes of these registers; there is no combinational path from i_spuEnable to any output.
  - Every decoded flag is gated by run.
- Reset (async, i_rst=1): all registers 0. Every output reads 0.
- Run control:
  - run <= i_spuEnable on every edge.
  - If i_spuEnable is sampled 0, cycCnt, slotCnt and capIdx are cleared on that edge.
- Start-up latency:
  - Edge E0 is the first edge at which i_spuEnable is sampled 1. At E0, run becomes 1 and the counters are still 0.
  - From E0, outputs show slot 0, cycle 0, with o_frameStart=1 and o_reverbInactive=1.
  - The counters first advance at E1.
- Advance rule (run=1 and i_spuEnable=1):
  - cycCnt increments.
  - When cycCnt == SLOT_CYCLES-1: cycCnt <= 0 and slotCnt increments.
  - When slotCnt == NUM_SLOTS-1 at that same point: slotCnt <= 0 and capIdx <= capIdx+1.
  - capIdx wraps from 2^CAPTURE_DEPTH_LOG2-1 to 0.
- Decodes:
  - o_voiceCounter = cycCnt.
  - o_currVoice = slotCnt.
  - o_reverbInactive = run & (slotCnt < NUM_VOICES).
  - o_reverbSlot = (slotCnt - NUM_VOICES) truncated to 3 bits when in a reverb slot, else 0.
  - o_frameStart = run & slotCnt==0 & cycCnt==0.
  - o_frameEnd = run & slotCnt==NUM_SLOTS-1 & cycCnt==SLOT_CYCLES-1.
  - o_captureIndex = capIdx.
- Frame period: exactly SLOT_CYCLES*NUM_SLOTS cycles between consecutive o_frameStart pulses, 768 with default parameters.
- Capture index timing: capIdx changes only on the edge that ends a frame. It is stable throughout every voice slot, so writes for voice 1 and voice 3 in one frame use the same index.
- Disable mid-frame (i_spuEnable sampled 0 at any cycle):
  - Next state: all outputs 0, counters 0, capIdx 0.
  - No partial-frame pulse is emitted.
  - Re-enable restarts at slot 0, cycle 0 per the start-up latency rule.
- Disable at the frame-wrap cycle: the clear takes priority over increment, so capIdx becomes 0, not capIdx+1.
- Reset mid-operation: immediate asynchronous clear of all registers. Recovery follows the start-up rule once i_rst deasserts and i_spuEnable is 1.
- Cycles in the range SLOT_CYCLES..31 never appear on o_voiceCounter.

Test Plan:
- Reset, then hold i_spuEnable=1 from the first edge. Required response:
  - o_frameStart=1 at E0.
  - o_voiceCounter steps 0..23, then o_currVoice=1 with o_isVoice1=1 at cycle 24 after E0.
  - The next o_frameStart arrives exactly 768 cycles after the first.
- Run one full frame and check the phase flag:
  - o_reverbInactive=1 for slots 0..23 (576 cycles), then 0 for slots 24..31.
  - o_reverbSlot steps 0..7 across the reverb slots.
  - o_frameEnd is a single pulse at slot 31, cycle 23.
- Run 513 frames:
  - o_captureIndex increments once per frame, reaches 511, then wraps to 0.
  - It changes only on the edge following o_frameEnd.
- Drop i_spuEnable at slot 10, cycle 7 for 3 cycles, then raise it:
  - All outputs go to 0 on the next edge.
  - After re-enable: o_frameStart=1, o_currVoice=0, o_captureIndex=0.
- Drop i_spuEnable exactly on the frame-wrap cycle with capIdx=5: capIdx becomes 0, not 6.
- Assert i_rst asynchronously at slot 3, cycle 12, between clock edges: all outputs read 0 immediately, before the next edge.

Source files
------------

// File: rtl/spu_slotsequencer.sv
// SPU slot sequencer: splits each sample frame into voice and reverb slots and
// publishes the in-slot cycle, slot index, phase flags and capture write index.
module spu_slotsequencer #(
   parameter int SLOT_CYCLES        = 24,
   parameter int NUM_SLOTS          = 32,
   parameter int NUM_VOICES         = 24,
   parameter int CAPTURE_DEPTH_LOG2 = 9
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_spuEnable,
   output logic [4:0]                    o_voiceCounter,
   output logic [4:0]                    o_currVoice,
   output logic                          o_reverbInactive,
   output logic [2:0]                    o_reverbSlot,
   output logic                          o_isVoice1,
   output logic                          o_isVoice3,
   output logic                          o_frameStart,
   output logic                          o_frameEnd,
   output logic [CAPTURE_DEPTH_LOG2-1:0] o_captureIndex
);

   localparam logic [4:0] LP_LAST_CYC    = 5'(SLOT_CYCLES - 1);
   localparam logic [4:0] LP_LAST_SLOT   = 5'(NUM_SLOTS - 1);
   localparam logic [4:0] LP_NUM_VOICES  = 5'(NUM_VOICES);
   localparam logic [2:0] LP_VOICE_OFS   = 3'(NUM_VOICES);
   localparam logic [CAPTURE_DEPTH_LOG2-1:0] LP_CAP_ONE = CAPTURE_DEPTH_LOG2'(1);

   logic                          r_run;
   logic [4:0]                    r_cycCnt;
   logic [4:0]                    r_slotCnt;
   logic [CAPTURE_DEPTH_LOG2-1:0] r_capIdx;

   logic w_lastCyc;
   logic w_lastSlot;
   logic w_inVoice;

   assign w_lastCyc  = (r_cycCnt == LP_LAST_CYC);
   assign w_lastSlot = (r_slotCnt == LP_LAST_SLOT);
   assign w_inVoice  = (r_slotCnt < LP_NUM_VOICES);

   // Counters only advance once run has been set for a cycle, so the first
   // enabled edge shows slot 0 / cycle 0; a low enable clears ahead of any wrap.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_run     <= 1'b0;
         r_cycCnt  <= '0;
         r_slotCnt <= '0;
         r_capIdx  <= '0;
      end else begin
         r_run <= i_spuEnable;
         if (!i_spuEnable) begin
            r_cycCnt  <= '0;
            r_slotCnt <= '0;
            r_capIdx  <= '0;
         end else if (r_run) begin
            if (w_lastCyc) begin
               r_cycCnt <= '0;
               if (w_lastSlot) begin
                  r_slotCnt <= '0;
                  r_capIdx  <= r_capIdx + LP_CAP_ONE;
               end else begin
                  r_slotCnt <= r_slotCnt + 5'd1;
               end
            end else begin
               r_cycCnt <= r_cycCnt + 5'd1;
            end
         end
      end
   end

   assign o_voiceCounter   = r_cycCnt;
   assign o_currVoice      = r_slotCnt;
   assign o_captureIndex   = r_capIdx;
   assign o_reverbInactive = r_run & w_inVoice;
   assign o_reverbSlot     = (r_run && !w_inVoice) ? (r_slotCnt[2:0] - LP_VOICE_OFS) : 3'd0;
   assign o_isVoice1       = r_run & (r_slotCnt == 5'd1);
   assign o_isVoice3       = r_run & (r_slotCnt == 5'd3);
   assign o_frameStart     = r_run & (r_slotCnt == 5'd0) & (r_cycCnt == 5'd0);
   assign o_frameEnd       = r_run & w_lastSlot & w_lastCyc;

endmodule
